// File: rtl/mux4way_pkg.sv
// Shared definitions for the 4-to-1 operand selector: the select encoding
// and the select type used by the top level and by its users.
package mux4way_pkg;

  // Two-bit selector type for the four data inputs.
  typedef logic [1:0] sel_t;

  // Select encoding: which data input appears on the output.
  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage : mux4way_pkg

// File: rtl/mux2way.sv
// 2-to-1 selector for WIDTH-bit buses; the leaf cell of the 4-way tree.
// A plain conditional operator is used so an unknown sel propagates as X
// on the differing bits instead of silently picking a default input.
module mux2way #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] out
);

  // sel=0 passes inA, sel=1 passes inB, bit for bit.
  assign out = sel ? inB : inA;

endmodule : mux2way

// File: rtl/mux_4way_8bit.sv
// 4-to-1 operand selector for the ALU/register-file datapath.
// 'out' is purely combinational (independent of clk and reset); 'out_q' and
// 'select_q' are one-cycle registered copies for the next pipeline stage.
// Optional feature: define MUX_4WAY_8BIT_PARITY_EN to add the even-parity
// outputs out_par (combinational) and out_par_q (registered).
module mux_4way_8bit
  import mux4way_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  sel_t             select,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  input  logic [WIDTH-1:0] inD,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output sel_t             select_q
`ifdef MUX_4WAY_8BIT_PARITY_EN
  ,
  output logic             out_par,
  output logic             out_par_q
`endif
);

  // First level of the tree: pair A/B and pair C/D on select[0].
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] hi_d;

  mux2way #(.WIDTH(WIDTH)) u_mux_lo (
    .sel (select[0]),
    .inA (inA),
    .inB (inB),
    .out (lo_d)
  );

  mux2way #(.WIDTH(WIDTH)) u_mux_hi (
    .sel (select[0]),
    .inA (inC),
    .inB (inD),
    .out (hi_d)
  );

  // Second level: choose between the two pairs on select[1].
  mux2way #(.WIDTH(WIDTH)) u_mux_out (
    .sel (select[1]),
    .inA (lo_d),
    .inB (hi_d),
    .out (out)
  );

`ifdef MUX_4WAY_8BIT_PARITY_EN
  // Even parity over the selected word, available with zero latency.
  assign out_par = ^out;
`endif

  // Pipeline register: capture the selected word and select; clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      select_q  <= SEL_A;
`ifdef MUX_4WAY_8BIT_PARITY_EN
      out_par_q <= 1'b0;
`endif
    end else begin
      out_q     <= out;
      select_q  <= select;
`ifdef MUX_4WAY_8BIT_PARITY_EN
      out_par_q <= out_par;
`endif
    end
  end

endmodule : mux_4way_8bit

// File: tb/tb_mux_4way_8bit.sv
// Self-checking bench for mux_4way_8bit: directed vectors, randomized
// vectors, back-to-back changes within a cycle and asynchronous reset.
module tb_mux_4way_8bit;
  import mux4way_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  sel_t             select;
  logic [WIDTH-1:0] inA, inB, inC, inD;
  logic [WIDTH-1:0] out, out_q;
  sel_t             select_q;
`ifdef MUX_4WAY_8BIT_PARITY_EN
  logic             out_par, out_par_q;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mux_4way_8bit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .select   (select),
    .inA      (inA),
    .inB      (inB),
    .inC      (inC),
    .inD      (inD),
    .out      (out),
    .out_q    (out_q),
    .select_q (select_q)
`ifdef MUX_4WAY_8BIT_PARITY_EN
    ,
    .out_par  (out_par),
    .out_par_q(out_par_q)
`endif
  );

  // Reference: the four inputs viewed as an array indexed by select.
  function automatic logic [WIDTH-1:0] ref_mux(input sel_t s, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v[s];
  endfunction

  task automatic drive(input sel_t s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    select = s; inA = a; inB = b; inC = c; inD = d;
  endtask

  task automatic report(input string name, input int fails_before);
    if (fails == fails_before) $display("%s: PASSED", name);
    else $display("%s: FAILED (%0d errors)", name, fails - fails_before);
  endtask

  // Drive one vector at the falling edge, check out, then check the registers.
  task automatic run_vector(input string name, input sel_t s, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                            input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    drive(s, a, b, c, d);
    exp = ref_mux(s, a, b, c, d);
    #1;
    checks++;
    if (out !== exp) begin
      fails++; $display("FAIL %s out: got %h expected %h (sel=%b)", name, out, exp, s);
    end else passed++;
    @(posedge clk); #1;
    checks++;
    if (out_q !== exp || select_q !== s) begin
      fails++;
      $display("FAIL %s regs: got out_q=%h select_q=%b expected %h %b", name, out_q, select_q, exp, s);
    end else passed++;
    $display("%s sel=%b A=%h B=%h C=%h D=%h out=%h out_q=%h", name, s, a, b, c, d, out, out_q);
  endtask

  task automatic test_reset();
    int f0 = fails;
    reset = 1'b1;
    drive(SEL_D, 8'h11, 8'h22, 8'h33, 8'h5A);
    #1;
    checks++;
    if (out_q !== '0 || select_q !== SEL_A) begin
      fails++; $display("FAIL reset_regs: got out_q=%h select_q=%b expected 00 00", out_q, select_q);
    end else passed++;
    checks++;
    if (out !== 8'h5A) begin
      fails++; $display("FAIL reset_out: got %h expected 5a", out);
    end else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_q !== '0 || select_q !== SEL_A) begin
      fails++; $display("FAIL reset_hold: got out_q=%h select_q=%b expected 00 00", out_q, select_q);
    end else passed++;
    @(negedge clk);
    reset = 1'b0;
    $display("reset released out_q=%h select_q=%b", out_q, select_q);
    report("test_reset", f0);
  endtask

  task automatic test_directed();
    int f0 = fails;
    run_vector("dir1",  SEL_A, 8'h2C, 8'h29, 8'h00, 8'hFF);
    run_vector("dir2a", SEL_B, 8'h13, 8'hDF, 8'hD2, 8'hEE);
    run_vector("dir2b", SEL_C, 8'hE8, 8'hFF, 8'h82, 8'hD3);
    run_vector("dir3a", SEL_D, 8'h02, 8'hD4, 8'h80, 8'hFC);
    run_vector("dir3b", SEL_D, 8'hC3, 8'h3C, 8'hCA, 8'hA3);
    run_vector("dir4a", SEL_A, 8'h8A, 8'h33, 8'h97, 8'h13);
    run_vector("dir4b", SEL_B, 8'h97, 8'h94, 8'h7B, 8'h73);
    run_vector("dir4c", SEL_C, 8'hF0, 8'h0F, 8'hAA, 8'h55);
    // Single-bit walks catch any reordered or inverted bit.
    for (int i = 0; i < WIDTH; i++)
      run_vector("walk", sel_t'(i % 4), 8'h01 << i, 8'h01 << i, 8'h01 << i, 8'h01 << i);
    report("test_directed", f0);
  endtask

  task automatic test_random();
    int f0 = fails;
    for (int i = 0; i < 40; i++)
      run_vector("rand", sel_t'($urandom_range(3)), WIDTH'($urandom), WIDTH'($urandom),
                 WIDTH'($urandom), WIDTH'($urandom));
    report("test_random", f0);
  endtask

  // Several select/data changes within one cycle: the register takes the last.
  task automatic test_back_to_back();
    int f0 = fails;
    sel_t s;
    logic [WIDTH-1:0] a, b, c, d, exp;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        s = sel_t'($urandom_range(3));
        a = WIDTH'($urandom); b = WIDTH'($urandom); c = WIDTH'($urandom); d = WIDTH'($urandom);
        drive(s, a, b, c, d);
        #1;
        exp = ref_mux(s, a, b, c, d);
        checks++;
        if (out !== exp) begin
          fails++; $display("FAIL b2b out: got %h expected %h", out, exp);
        end else passed++;
      end
      @(posedge clk); #1;
      checks++;
      if (out_q !== exp || select_q !== s) begin
        fails++;
        $display("FAIL b2b regs: got out_q=%h select_q=%b expected %h %b", out_q, select_q, exp, s);
      end else passed++;
      $display("b2b sel=%b out_q=%h", s, out_q);
    end
    report("test_back_to_back", f0);
  endtask

  task automatic test_reset_midrun();
    int f0 = fails;
    run_vector("pre_rst", SEL_C, 8'h12, 8'h34, 8'hAA, 8'h56);
    #2;  // between edges
    reset = 1'b1;
    #1;
    checks++;
    if (out_q !== '0 || select_q !== SEL_A) begin
      fails++; $display("FAIL midrun_clear: got out_q=%h select_q=%b expected 00 00", out_q, select_q);
    end else passed++;
    checks++;
    if (out !== 8'hAA) begin
      fails++; $display("FAIL midrun_out: got %h expected aa", out);
    end else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_q !== 8'hAA || select_q !== SEL_C) begin
      fails++; $display("FAIL midrun_release: got out_q=%h select_q=%b expected aa 10", out_q, select_q);
    end else passed++;
    $display("midrun reset released out_q=%h select_q=%b", out_q, select_q);
    report("test_reset_midrun", f0);
  endtask

`ifdef MUX_4WAY_8BIT_PARITY_EN
  task automatic test_parity();
    int f0 = fails;
    logic [WIDTH-1:0] v [2];
    logic exp;
    v[0] = 8'hAA; v[1] = 8'h94;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(SEL_B, 8'h00, v[i], 8'h00, 8'h00);
      exp = 1'b0;
      for (int b = 0; b < WIDTH; b++) exp = exp ^ v[i][b];
      #1;
      checks++;
      if (out_par !== exp) begin
        fails++; $display("FAIL parity: got %b expected %b for %h", out_par, exp, v[i]);
      end else passed++;
      @(posedge clk); #1;
      checks++;
      if (out_par_q !== exp) begin
        fails++; $display("FAIL parity_q: got %b expected %b for %h", out_par_q, exp, v[i]);
      end else passed++;
      $display("parity out=%h out_par=%b", out, out_par);
    end
    report("test_parity", f0);
  endtask
`endif

  initial begin
    drive(SEL_A, '0, '0, '0, '0);
    reset = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
`ifdef MUX_4WAY_8BIT_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_mux_4way_8bit
